// File: rtl/fp_mc_pkg.sv
// Shared types and constants for the multi-cycle FP sequencer.
`default_nettype none

package fp_mc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    WB   = 2'b10
  } state_e;

  localparam logic [1:0]  FMUL      = 2'b00;
  localparam logic [1:0]  FDIV      = 2'b01;
  localparam logic [1:0]  FSQRT     = 2'b10;
  localparam logic [31:0] CANON_NAN = 32'h7FC00000;
  localparam logic [4:0]  FLAG_NV   = 5'b10000;

endpackage

`default_nettype wire

// File: rtl/fp_mc_watchdog.sv
// RUN-cycle counter that pulses timeout on the last permitted RUN cycle.
`default_nettype none

module fp_mc_watchdog #(
  parameter int WDOG_CYCLES = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic run,
  output logic timeout
);

  localparam int CW = $clog2(WDOG_CYCLES + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (run && (cnt != CW'(WDOG_CYCLES))) begin
      cnt <= cnt + 1'b1;
    end
  end

  // cnt holds the number of RUN cycles already completed
  assign timeout = run && (cnt == CW'(WDOG_CYCLES - 1));

endmodule

`default_nettype wire

// File: rtl/fp_multicycle_sched.sv
// Sequencer for the multi-cycle FP unit: start/done handshake, pending-rd stall, regfile write arbitration.
// Optional watchdog abort enabled by defining FP_MC_WATCHDOG_EN.
`default_nettype none

module fp_multicycle_sched
  import fp_mc_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int REG_AW      = 5,
  parameter int WDOG_CYCLES = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid_i,
  input  logic [1:0]        ex_op_i,
  input  logic [REG_AW-1:0] ex_rd_i,
  input  logic [XLEN-1:0]   ex_a_i,
  input  logic [XLEN-1:0]   ex_b_i,
  input  logic [REG_AW-1:0] dec_rs1_i,
  input  logic [REG_AW-1:0] dec_rs2_i,
  input  logic              dec_mc_i,
  output logic              fpu_start_o,
  output logic [1:0]        fpu_op_o,
  output logic [XLEN-1:0]   fpu_a_o,
  output logic [XLEN-1:0]   fpu_b_o,
  input  logic              fpu_done_i,
  input  logic [XLEN-1:0]   fpu_result_i,
  input  logic [4:0]        fpu_flags_i,
  input  logic              wb_port_busy_i,
  output logic              fwr_en_o,
  output logic [REG_AW-1:0] fwr_addr_o,
  output logic [XLEN-1:0]   fwr_data_o,
  output logic [4:0]        fflags_o,
  output logic              stall_o,
  output logic              busy_o,
  output logic              err_o
);

  state_e            state, state_nx;
  logic              first_run;
  logic [1:0]        op_q;
  logic [REG_AW-1:0] rd_q;
  logic [XLEN-1:0]   a_q, b_q, result_q;
  logic [4:0]        flags_q;
  logic              accept, done_ok, timeout_fire, in_run;
  logic              hit_rs1, hit_rs2, struct_hit;

  assign in_run  = (state == RUN);
  assign accept  = (state == IDLE) && ex_valid_i;
  // A done coinciding with the start pulse cannot belong to this op
  assign done_ok = in_run && !first_run && fpu_done_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    fwr_en_o = 1'b0;
    case (state)
      IDLE: if (ex_valid_i) state_nx = RUN;
      RUN:  if (done_ok || timeout_fire) state_nx = WB;
      WB: begin
        fwr_en_o = !wb_port_busy_i;
        if (!wb_port_busy_i) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      first_run <= 1'b0;
      op_q      <= '0;
      rd_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      result_q  <= '0;
      flags_q   <= '0;
    end else begin
      first_run <= accept;
      if (accept) begin
        op_q <= ex_op_i;
        rd_q <= ex_rd_i;
        a_q  <= ex_a_i;
        b_q  <= ex_b_i;
      end
      if (done_ok) begin
        result_q <= fpu_result_i;
        flags_q  <= fpu_flags_i;
      end else if (timeout_fire) begin
        result_q <= XLEN'(CANON_NAN);
        flags_q  <= FLAG_NV;
      end
    end
  end

`ifdef FP_MC_WATCHDOG_EN
  logic wdog_timeout;
  logic err_q;

  fp_mc_watchdog #(
    .WDOG_CYCLES (WDOG_CYCLES)
  ) u_wdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (accept),
    .run     (in_run),
    .timeout (wdog_timeout)
  );

  assign timeout_fire = wdog_timeout && !done_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            err_q <= 1'b0;
    else if (timeout_fire) err_q <= 1'b1;
  end

  assign err_o = err_q;
`else
  logic unused_wdog;
  assign unused_wdog  = (WDOG_CYCLES > 0);
  assign timeout_fire = 1'b0;
  assign err_o        = 1'b0;
`endif

  assign busy_o      = (state != IDLE);
  assign fpu_start_o = first_run;
  assign fpu_op_o    = op_q;
  assign fpu_a_o     = a_q;
  assign fpu_b_o     = b_q;
  assign fwr_addr_o  = rd_q;
  assign fwr_data_o  = result_q;
  assign fflags_o    = flags_q;

  // f0 is a real register, so no zero-index exclusion
  assign hit_rs1    = (busy_o && (dec_rs1_i == rd_q)) ||
                      (accept && (dec_rs1_i == ex_rd_i));
  assign hit_rs2    = (busy_o && (dec_rs2_i == rd_q)) ||
                      (accept && (dec_rs2_i == ex_rd_i));
  assign struct_hit = dec_mc_i && (busy_o || ex_valid_i);
  assign stall_o    = hit_rs1 || hit_rs2 || struct_hit;

endmodule

`default_nettype wire

// File: tb/tb_fp_multicycle_sched.sv
// Directed bench for fp_multicycle_sched with a write-port scoreboard.
`default_nettype none

module tb_fp_multicycle_sched;

  localparam int WDOG = 8;
`ifdef FP_MC_WATCHDOG_EN
  localparam int LAT1 = 5;
`else
  localparam int LAT1 = 10;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid;
  logic [1:0]  ex_op;
  logic [4:0]  ex_rd;
  logic [31:0] ex_a, ex_b;
  logic [4:0]  dec_rs1, dec_rs2;
  logic        dec_mc;
  logic        fpu_start_o;
  logic [1:0]  fpu_op_o;
  logic [31:0] fpu_a_o, fpu_b_o;
  logic        fpu_done;
  logic [31:0] fpu_result;
  logic [4:0]  fpu_flags;
  logic        wb_busy;
  logic        fwr_en_o;
  logic [4:0]  fwr_addr_o;
  logic [31:0] fwr_data_o;
  logic [4:0]  fflags_o;
  logic        stall_o, busy_o, err_o;

  int n_cmp = 0;
  int n_err = 0;
  logic [41:0] sb[$];

  fp_multicycle_sched #(.XLEN(32), .REG_AW(5), .WDOG_CYCLES(WDOG)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid_i(ex_valid), .ex_op_i(ex_op), .ex_rd_i(ex_rd),
    .ex_a_i(ex_a), .ex_b_i(ex_b),
    .dec_rs1_i(dec_rs1), .dec_rs2_i(dec_rs2), .dec_mc_i(dec_mc),
    .fpu_start_o(fpu_start_o), .fpu_op_o(fpu_op_o),
    .fpu_a_o(fpu_a_o), .fpu_b_o(fpu_b_o),
    .fpu_done_i(fpu_done), .fpu_result_i(fpu_result), .fpu_flags_i(fpu_flags),
    .wb_port_busy_i(wb_busy),
    .fwr_en_o(fwr_en_o), .fwr_addr_o(fwr_addr_o), .fwr_data_o(fwr_data_o),
    .fflags_o(fflags_o), .stall_o(stall_o), .busy_o(busy_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n === 1'b1 && ex_valid === 1'b1)
      assert (busy_o !== 1'b1) else $error("protocol violation: ex_valid while busy");
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ctl"}, {fpu_start_o, fpu_op_o, fwr_en_o, fwr_addr_o, fflags_o, stall_o, busy_o, err_o}, 64'd0);
    chk({tag, "_ops"}, {fpu_a_o, fpu_b_o}, 64'd0);
    chk({tag, "_data"}, fwr_data_o, 64'd0);
  endtask

  // Accept one op, play the FP unit, then collect and score the write.
  task automatic run_op(input logic [1:0] op, input logic [4:0] rd, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] res, input logic [4:0] fl, input int lat, input int busy_n,
                        input logic exp_stall, input logic early_done);
    int starts;
    int early;
    logic [41:0] exp_wr;
    starts = 0;
    early  = 0;
    ex_valid = 1'b1; ex_op = op; ex_rd = rd; ex_a = a; ex_b = b;
    sb.push_back({rd, res, fl});
    #1;
    chk("accept_stall", stall_o, exp_stall);
    chk("accept_busy", busy_o, 1'b0);
    tick();
    ex_valid = 1'b0; ex_op = 2'b11; ex_rd = 5'd0; ex_a = '0; ex_b = '0;
    fpu_done = early_done; fpu_result = early_done ? 32'hDEADBEEF : 32'h0;
    #1;
    starts += int'(fpu_start_o);
    chk("latched_op", fpu_op_o, op);
    chk("latched_ab", {fpu_a_o, fpu_b_o}, {a, b});
    chk("run_busy", busy_o, 1'b1);
    chk("run_stall", stall_o, exp_stall);
    for (int k = 1; k <= lat; k++) begin
      tick();
      fpu_done   = (k == lat);
      fpu_result = (k == lat) ? res : 32'h0;
      fpu_flags  = (k == lat) ? fl : 5'h0;
      wb_busy    = (k == lat) && (busy_n > 0);
      #1;
      starts += int'(fpu_start_o);
      early  += int'(fwr_en_o);
      chk("run_stall_k", stall_o, exp_stall);
    end
    tick();
    fpu_done = 1'b0; fpu_result = 32'h0; fpu_flags = 5'h0;
    exp_wr = sb[0];
    for (int j = 0; j < busy_n; j++) begin
      #1;
      chk("wb_hold_en", fwr_en_o, 1'b0);
      chk("wb_hold_data", {fwr_addr_o, fwr_data_o, fflags_o}, exp_wr);
      tick();
      wb_busy = (j + 1 < busy_n);
    end
    #1;
    chk("wr_en", fwr_en_o, 1'b1);
    chk("wr_stall", stall_o, exp_stall);
    chk("sb_nonempty", sb.size() != 0, 1'b1);
    if (sb.size() != 0) chk("wr_payload", {fwr_addr_o, fwr_data_o, fflags_o}, sb.pop_front());
    chk("start_pulses", starts, 1);
    chk("no_early_write", early, 0);
    tick();
    #1;
    chk("after_busy", busy_o, 1'b0);
    chk("after_en", fwr_en_o, 1'b0);
    chk("after_stall", stall_o, 1'b0);
  endtask

  initial begin
    int wrs;
    int c;
    rst_n = 1'b0; ex_valid = 1'b0; ex_op = 2'b00; ex_rd = 5'd0; ex_a = '0; ex_b = '0;
    dec_rs1 = 5'd31; dec_rs2 = 5'd31; dec_mc = 1'b0;
    fpu_done = 1'b0; fpu_result = '0; fpu_flags = '0; wb_busy = 1'b0;
    #3;
    chk_all_zero("reset");
    tick();
    rst_n = 1'b1;
    #1;
    chk_all_zero("post_reset");

    // Basic FDIV to f5, done 10 cycles after start
    run_op(2'b01, 5'd5, 32'h40400000, 32'h40400000, 32'h3F800000, 5'b00001, LAT1, 0, 1'b0, 1'b0);

    // Pending destination rd=7 seen on rs2
    dec_rs1 = 5'd0; dec_rs2 = 5'd7;
    run_op(2'b00, 5'd7, 32'h3FC00000, 32'h40000000, 32'h40400000, 5'b00000, 4, 0, 1'b1, 1'b0);
    dec_rs1 = 5'd8; dec_rs2 = 5'd8;
    run_op(2'b00, 5'd7, 32'h11111111, 32'h22222222, 32'h33333333, 5'b00001, 3, 0, 1'b0, 1'b0);

    // f0 is a real destination: rs1=0 must hit
    dec_rs1 = 5'd0;
    run_op(2'b10, 5'd0, 32'h40800000, 32'h0, 32'h40000000, 5'b00000, 2, 0, 1'b1, 1'b0);
    dec_rs1 = 5'd8;

    // Structural hazard: multi-cycle op in ID throughout
    dec_mc = 1'b1;
    run_op(2'b01, 5'd3, 32'hAAAA5555, 32'h5555AAAA, 32'h12345678, 5'b00100, 3, 0, 1'b1, 1'b0);
    #1;
    chk("idle_mc_no_stall", stall_o, 1'b0);
    dec_mc = 1'b0;

    // Write port busy for 3 cycles, asserted together with done
    run_op(2'b00, 5'd9, 32'h01020304, 32'h05060708, 32'hCAFEF00D, 5'b00011, 3, 3, 1'b0, 1'b0);

    // Minimum latency and a done in the start cycle being ignored
    run_op(2'b10, 5'd12, 32'h0BADF00D, 32'h0, 32'h7F7FFFFF, 5'b00101, 1, 0, 1'b0, 1'b0);
    run_op(2'b01, 5'd13, 32'h3, 32'h4, 32'h87654321, 5'b01000, 3, 0, 1'b0, 1'b1);

    // Reset mid-RUN abandons the op
    ex_valid = 1'b1; ex_op = 2'b01; ex_rd = 5'd10; ex_a = 32'h9; ex_b = 32'h8;
    tick();
    ex_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    chk_all_zero("midrun_reset");
    tick();
    rst_n = 1'b1; fpu_done = 1'b1; fpu_result = 32'h12345678; fpu_flags = 5'b11111;
    tick();
    fpu_done = 1'b0; fpu_result = '0; fpu_flags = '0;
    wrs = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      wrs += int'(fwr_en_o);
      tick();
    end
    chk("abandoned_writes", wrs, 0);
    #1;
    chk_all_zero("after_abandon");

`ifdef FP_MC_WATCHDOG_EN
    ex_valid = 1'b1; ex_op = 2'b01; ex_rd = 5'd12; ex_a = 32'h1; ex_b = 32'h0;
    sb.push_back({5'd12, 32'h7FC00000, 5'b10000});
    tick();
    ex_valid = 1'b0;
    c = 1;
    #1;
    while (!fwr_en_o && c <= 20) begin
      tick();
      c++;
      #1;
    end
    chk("wdog_latency", c, WDOG + 1);
    chk("wdog_payload", {fwr_addr_o, fwr_data_o, fflags_o}, sb.pop_front());
    chk("wdog_err", err_o, 1'b1);
    tick();
    fpu_done = 1'b1; fpu_result = 32'h3F800000;
    tick();
    fpu_done = 1'b0; fpu_result = '0;
    #1;
    chk("wdog_late_done_idle", {busy_o, fwr_en_o}, 2'b00);
    chk("wdog_err_sticky", err_o, 1'b1);
    tick();
    rst_n = 1'b0;
    #1;
    chk("wdog_err_reset", err_o, 1'b0);
    tick();
    rst_n = 1'b1;
`else
    c = 0;
`endif
    #1;
    chk("err_final", err_o, 1'b0);
    chk("sb_drained", sb.size(), 0);
    chk("unused_c_marker", c >= 0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fp_multicycle_sched.md
Name: fp_multicycle_sched

Overview:
- Sequences the multi-cycle FP unit (FDIV/FSQRT/FMUL): accepts one op from EX, drives the unit's start/done handshake, holds its destination as pending and arbitrates the FP register-file write port.
- Raises a stall toward the hazard unit; top level ORs it into StallF/StallD and FlushE, alongside lwStall.
- One op outstanding at a time.

Parameters:
- XLEN, 32, FP operand/result width
- REG_AW, 5, FP register address width
- WDOG_CYCLES, 64, watchdog limit in RUN cycles (used only with the optional feature)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- ex_valid_i  in  1  valid multi-cycle FP op in EX (bubbles already excluded)
- ex_op_i  in  2  op code (fp_mc_pkg)
- ex_rd_i  in  REG_AW  FP destination
- ex_a_i, ex_b_i  in  XLEN  operands (post-forwarding)
- dec_rs1_i, dec_rs2_i  in  REG_AW  FP sources of the instruction in ID
- dec_mc_i  in  1  instruction in ID is a multi-cycle FP op
- fpu_start_o  out  1  one-cycle start pulse
- fpu_op_o  out  2  latched op
- fpu_a_o, fpu_b_o  out  XLEN  latched operands
- fpu_done_i  in  1  result valid, one-cycle pulse
- fpu_result_i  in  XLEN  result
- fpu_flags_i  in  5  NV,DZ,OF,UF,NX
- wb_port_busy_i  in  1  pipeline WB writes the FP regfile this cycle (pipeline has priority)
- fwr_en_o  out  1  FP regfile write enable
- fwr_addr_o  out  REG_AW  write address
- fwr_data_o  out  XLEN  write data
- fflags_o  out  5  flags to accrue; valid when fwr_en_o
- stall_o  out  1  stall request (combinational)
- busy_o  out  1  state != IDLE
- err_o  out  1  sticky watchdog error

Behaviour:
- Reset (async, rst_n=0): state IDLE. All outputs 0, including the latched op/rd/operands/result and err_o. Reset mid-op abandons the op with no write. The FP unit shares rst_n.
- IDLE:
  - ex_valid_i=1 latches op, rd, a, b and moves to RUN.
  - fpu_start_o=1 in exactly the first RUN cycle.
- RUN:
  - fpu_done_i is ignored in the start cycle.
  - On a later fpu_done_i, latch result and flags, then go to WB.
  - Minimum IDLE-to-write latency is 3 cycles.
- WB:
  - fwr_en_o = !wb_port_busy_i.
  - fwr_addr_o is the latched rd; fwr_data_o and fflags_o are the latched values.
  - On a write cycle, go to IDLE. If the port is busy, hold WB with the data stable (no limit).
  - fpu_done_i is ignored in WB.
- ex_valid_i while busy_o=1 is a protocol violation: ignored, flagged by a bench assertion.
- Pending destination:
  - pend_hit = (busy_o && rs==latched rd) || (state==IDLE && ex_valid_i && rs==ex_rd_i), evaluated for rs1 and rs2.
  - f0 is a real register; there is no zero exclusion.
- Structural hit: struct_hit = dec_mc_i && (busy_o || ex_valid_i).
- stall_o = pend_hit_rs1 || pend_hit_rs2 || struct_hit.
  - stall_o stays high through the write cycle and drops the cycle after, when state is IDLE.
  - The regfile need not be write-through.
- Simultaneous done and wb_port_busy_i: done is latched; the write is deferred by the WB rule.

Optional Feature:
- Macro FP_MC_WATCHDOG_EN.
- Defined:
  - Counter increments each RUN cycle and clears on entering RUN.
  - If it reaches WDOG_CYCLES without done, go to WB with result 32'h7FC00000 and flags 5'b10000.
  - err_o is set and stays sticky until reset.
  - A late fpu_done_i after the abort is ignored.
- Undefined: no counter; err_o tied 0; RUN waits indefinitely.

Decomposition:
- fp_mc_pkg:
  - state enum IDLE/RUN/WB
  - op codes FMUL=2'b00, FDIV=2'b01, FSQRT=2'b10
  - CANON_NAN=32'h7FC00000, FLAG_NV=5'b10000
- Sub-module fp_mc_watchdog (counter plus timeout pulse), instantiated only under FP_MC_WATCHDOG_EN.

Test Plan:
- Reset release, ex_valid_i=1, op=FDIV, rd=5, done 10 cycles after start, result 32'h3F800000, wb_port_busy_i=0 -> exactly one fpu_start_o pulse; fwr_en_o=1 with addr 5 and data 32'h3F800000 in the cycle after done; busy_o returns to 0.
- Op pending rd=7, dec_rs2_i=7 -> stall_o=1 from the accept cycle through the write cycle, 0 the cycle after; with dec_rs1_i=dec_rs2_i=8, stall_o stays 0.
- Op in RUN, dec_mc_i=1 -> stall_o=1. Then ex_valid_i=1 with dec_mc_i=1 in the same IDLE cycle -> stall_o=1 and the op in EX is accepted.
- done arrives while wb_port_busy_i=1 for 3 cycles -> fwr_en_o=0 for 3 cycles with data held; fwr_en_o=1 on the 4th cycle.
- rst_n pulsed low mid-RUN, then done pulses -> state IDLE, no fwr_en_o, all outputs 0.
- FP_MC_WATCHDOG_EN with WDOG_CYCLES=8, no done -> after 8 RUN cycles, write of 32'h7FC00000 with fflags_o=5'b10000; err_o=1 until reset.
